// File: rtl/pulse_stopwatch_pkg.sv
// Shared types and constants for the MM:SS pulse stopwatch.
package pulse_stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] min1;
    logic [DIGIT_W-1:0] min0;
    logic [DIGIT_W-1:0] sec1;
    logic [DIGIT_W-1:0] sec0;
  } digits_t;

  // Active-high segment patterns, bit 0 = seg a .. bit 6 = seg g
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/pulse_stopwatch_bcd_to_seg7.sv
// BCD digit to 7-segment decoder; non-BCD codes blank the display.
module bcd_to_seg7
  import pulse_stopwatch_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg_c
);

  logic [SEG_W-1:0] pattern;

  always_comb begin
    pattern = SEG_BLANK;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

  assign seg_c = SEG_ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: rtl/pulse_stopwatch.sv
// MM:SS BCD stopwatch counting 1 Hz pulses, with start/stop/clear keys and 7-seg drive.
// Optional lap-hold display freeze enabled by defining PULSE_STOPWATCH_LAP_HOLD_EN.
module pulse_stopwatch
  import pulse_stopwatch_pkg::*;
#(
  parameter int unsigned MIN_LIMIT      = 59,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               Clk,
  input  logic               Resetn,
  input  logic               Pulse,
  input  logic               StartStop,
  input  logic               Clear,
`ifdef PULSE_STOPWATCH_LAP_HOLD_EN
  input  logic               LapHold,
`endif
  output logic [DIGIT_W-1:0] Sec0,
  output logic [DIGIT_W-1:0] Sec1,
  output logic [DIGIT_W-1:0] Min0,
  output logic [DIGIT_W-1:0] Min1,
  output logic [SEG_W-1:0]   HEX0,
  output logic [SEG_W-1:0]   HEX1,
  output logic [SEG_W-1:0]   HEX2,
  output logic [SEG_W-1:0]   HEX3,
  output logic               Running,
  output logic               Rollover
);

  localparam logic [DIGIT_W-1:0] MIN_TENS  = 4'(MIN_LIMIT / 10);
  localparam logic [DIGIT_W-1:0] MIN_UNITS = 4'(MIN_LIMIT % 10);

  state_t  state, state_next;
  digits_t dig, dig_next, disp;
  logic    ss_q, ss_rise, roll_next;

  assign ss_rise = StartStop & ~ss_q;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      dig      <= '0;
      ss_q     <= 1'b0;
      Running  <= 1'b0;
      Rollover <= 1'b0;
    end else begin
      state    <= state_next;
      dig      <= dig_next;
      ss_q     <= StartStop;
      Running  <= (state_next == RUN);
      Rollover <= roll_next;
    end
  end

  // Clear outranks key edges and pulses; a pulse only counts while already in RUN
  always_comb begin
    state_next = state;
    dig_next   = dig;
    roll_next  = 1'b0;
    if (Clear) begin
      state_next = IDLE;
      dig_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          dig_next = '0;
          if (ss_rise) state_next = RUN;
        end
        RUN: begin
          if (ss_rise) state_next = PAUSE;
          if (Pulse) begin
            if (dig.sec0 != 4'd9) begin
              dig_next.sec0 = dig.sec0 + 4'd1;
            end else begin
              dig_next.sec0 = '0;
              if (dig.sec1 != 4'd5) begin
                dig_next.sec1 = dig.sec1 + 4'd1;
              end else begin
                dig_next.sec1 = '0;
                if (dig.min1 == MIN_TENS && dig.min0 == MIN_UNITS) begin
                  dig_next.min1 = '0;
                  dig_next.min0 = '0;
                  roll_next     = 1'b1;
                end else if (dig.min0 != 4'd9) begin
                  dig_next.min0 = dig.min0 + 4'd1;
                end else begin
                  dig_next.min0 = '0;
                  dig_next.min1 = dig.min1 + 4'd1;
                end
              end
            end
          end
        end
        PAUSE: begin
          if (ss_rise) state_next = RUN;
        end
        default: begin
          state_next = IDLE;
          dig_next   = '0;
        end
      endcase
    end
  end

  assign Sec0 = dig.sec0;
  assign Sec1 = dig.sec1;
  assign Min0 = dig.min0;
  assign Min1 = dig.min1;

`ifdef PULSE_STOPWATCH_LAP_HOLD_EN
  logic    lap_q;
  digits_t lap_dig;

  // Snapshot the live digits on the LapHold rising edge; display it while held
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      lap_q   <= 1'b0;
      lap_dig <= '0;
    end else begin
      lap_q <= LapHold;
      if (Clear) lap_dig <= '0;
      else if (LapHold && !lap_q) lap_dig <= dig;
    end
  end

  assign disp = lap_q ? lap_dig : dig;
`else
  assign disp = dig;
`endif

  bcd_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg0 (.digit(disp.sec0), .seg_c(HEX0));
  bcd_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg1 (.digit(disp.sec1), .seg_c(HEX1));
  bcd_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg2 (.digit(disp.min0), .seg_c(HEX2));
  bcd_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg3 (.digit(disp.min1), .seg_c(HEX3));

endmodule

// File: tb/tb_pulse_stopwatch.sv
// Bench for pulse_stopwatch: vector table, corner sequences and random run vs a seconds-count model.
module tb_pulse_stopwatch;

  localparam int LIMIT   = 59;
  localparam int WRAP    = (LIMIT + 1) * 60;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       resetn, pulse, start_stop, clear, lap_hold;
  logic [3:0] sec0, sec1, min0, min1;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       running, rollover;

  int errors = 0;
  int checks = 0;

  // Model state: elapsed seconds as one integer plus mode and edge memory
  int m_mode, m_total, m_lap_total;
  bit m_ss_q, m_roll, m_lap_q;

  typedef struct {
    bit p;
    bit s;
    bit c;
    int reps;
    int exp_total;
    bit exp_run;
    bit exp_roll;
  } vec_t;
  vec_t vecs[$];

  pulse_stopwatch #(.MIN_LIMIT(LIMIT), .SEG_ACTIVE_LOW(1'b1)) dut (
    .Clk(clk), .Resetn(resetn), .Pulse(pulse), .StartStop(start_stop), .Clear(clear),
`ifdef PULSE_STOPWATCH_LAP_HOLD_EN
    .LapHold(lap_hold),
`endif
    .Sec0(sec0), .Sec1(sec1), .Min0(min0), .Min1(min1),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
    .Running(running), .Rollover(rollover)
  );

  always #5 clk = ~clk;

  // Active-low patterns as they appear on a DE board
  function automatic logic [6:0] seg_al(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int t);
    int s, m;
    s = t % 60;
    m = t / 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [27:0] to_hex(input int t);
    int s, m;
    s = t % 60;
    m = t / 60;
    return {seg_al(m / 10), seg_al(m % 10), seg_al(s / 10), seg_al(s % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int shown;
    shown = m_lap_q ? m_lap_total : m_total;
    check({tag, "_digits"}, 32'({min1, min0, sec1, sec0}), 32'(to_bcd(m_total)));
    check({tag, "_flags"}, 32'({running, rollover}), 32'({m_mode == M_RUN, m_roll}));
    check({tag, "_hex"}, 32'({hex3, hex2, hex1, hex0}), 32'(to_hex(shown)));
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_total = 0; m_ss_q = 0; m_roll = 0; m_lap_q = 0; m_lap_total = 0;
  endtask

  task automatic model_update(input bit p, input bit s, input bit c);
    int old;
    bit rise;
    old  = m_total;
    rise = s && !m_ss_q;
    m_roll = 0;
    if (c) begin
      m_mode  = M_IDLE;
      m_total = 0;
    end else if (m_mode == M_RUN) begin
      if (p) begin
        m_total = (m_total + 1) % WRAP;
        m_roll  = (m_total == 0);
      end
      if (rise) m_mode = M_PAUSE;
    end else if (rise) begin
      m_mode = M_RUN;
    end
    m_ss_q = s;
    if (c) m_lap_total = 0;
    else if (lap_hold && !m_lap_q) m_lap_total = old;
    m_lap_q = lap_hold;
  endtask

  task automatic step(input bit p, input bit s, input bit c, input string tag);
    pulse = p; start_stop = s; clear = c;
    @(posedge clk);
    #1;
    model_update(p, s, c);
    check_all(tag);
  endtask

  initial begin
    bit s_cur;
    resetn = 0; pulse = 0; start_stop = 0; clear = 0; lap_hold = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1;
    #1;
    check("reset_hex0", 32'(hex0), 32'(7'b1000000));
    check_all("reset");

    // {pulse, startstop, clear, reps, expected seconds, running, rollover}
    vecs.push_back('{1, 0, 0, 10,   0,    0, 0}); // pulses ignored in IDLE
    vecs.push_back('{0, 1, 0, 1,    0,    1, 0}); // start
    vecs.push_back('{1, 0, 0, 61,   61,   1, 0}); // 01:01
    vecs.push_back('{0, 0, 0, 1,    61,   1, 0});
    vecs.push_back('{0, 0, 1, 1,    0,    0, 0}); // clear
    vecs.push_back('{0, 1, 0, 1,    0,    1, 0});
    vecs.push_back('{1, 0, 0, 59,   59,   1, 0}); // 00:59
    vecs.push_back('{1, 1, 0, 1,    60,   0, 0}); // pulse counted, go PAUSE
    vecs.push_back('{1, 1, 0, 5,    60,   0, 0}); // held key, pulses ignored
    vecs.push_back('{1, 0, 0, 5,    60,   0, 0});
    vecs.push_back('{1, 1, 0, 1,    60,   1, 0}); // resume, pulse not counted
    vecs.push_back('{1, 0, 0, 1,    61,   1, 0});
    vecs.push_back('{0, 0, 1, 1,    0,    0, 0});
    vecs.push_back('{0, 1, 0, 1,    0,    1, 0});
    vecs.push_back('{1, 0, 0, 754,  754,  1, 0}); // 12:34
    vecs.push_back('{1, 1, 1, 1,    0,    0, 0}); // clear beats pulse and key
    vecs.push_back('{0, 1, 0, 1,    0,    0, 0}); // key still high, no new edge
    vecs.push_back('{0, 0, 0, 1,    0,    0, 0});
    vecs.push_back('{0, 1, 0, 1,    0,    1, 0});
    vecs.push_back('{1, 0, 0, 3599, 3599, 1, 0}); // 59:59
    vecs.push_back('{1, 0, 0, 1,    0,    1, 1}); // wrap strobe
    vecs.push_back('{0, 0, 0, 1,    0,    1, 0}); // strobe lasts one cycle
    vecs.push_back('{1, 0, 0, 1,    1,    1, 0});

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) step(vecs[i].p, vecs[i].s, vecs[i].c, "step");
      check($sformatf("vec%0d_digits", i), 32'({min1, min0, sec1, sec0}), 32'(to_bcd(vecs[i].exp_total)));
      check($sformatf("vec%0d_flags", i), 32'({running, rollover}), 32'({vecs[i].exp_run, vecs[i].exp_roll}));
    end

    // Asynchronous reset mid-count must clear without a clock edge
    repeat (25) step(1, 0, 0, "pre_reset");
    #2 resetn = 0;
    #1;
    check("async_reset_digits", 32'({min1, min0, sec1, sec0, running}), 32'(0));
    check("async_reset_hex0", 32'(hex0), 32'(7'b1000000));
    model_reset();
    @(negedge clk) resetn = 1;

`ifdef PULSE_STOPWATCH_LAP_HOLD_EN
    step(0, 1, 0, "lap_start");
    repeat (10) step(1, 0, 0, "lap_cnt");
    lap_hold = 1;
    repeat (5) step(1, 0, 0, "lap_held");
    check("lap_frozen_hex", 32'({hex1, hex0}), 32'({seg_al(1), seg_al(0)}));
    check("lap_live_secs", 32'({sec1, sec0}), 32'({4'd1, 4'd5}));
    lap_hold = 0;
    step(0, 0, 0, "lap_release");
    check("lap_release_hex", 32'({hex1, hex0}), 32'({seg_al(1), seg_al(5)}));
    step(0, 0, 1, "lap_clear");
`endif

    // Random run against the model
    s_cur = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) s_cur = ~s_cur;
`ifdef PULSE_STOPWATCH_LAP_HOLD_EN
      if ($urandom_range(0, 31) == 0) lap_hold = ~lap_hold;
`endif
      step($urandom_range(0, 2) == 0, s_cur, $urandom_range(0, 299) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
